// File: rtl/clk_mgr_a.sv
// clk_mgr_a
//
// Purpose:
//   Single-clock "clock manager" that produces clock-enable strobes rather
//   than real clocks. Each strobe channel uses a phase accumulator: every
//   locked cycle the channel adds its increment, and the registered
//   carry-out becomes a one-cycle enable pulse. Over time the pulses average
//   out to the channel's target frequency. A lock counter holds every channel
//   idle for LOCK_CYCLES cycles after reset. Because all channels start
//   accumulating on the same cycle, they begin phase-aligned.
//
// Ports:
//   OSC_IN          - the only clock; all logic runs on its rising edge
//   RST             - synchronous active-high reset
//   OSC_OUT         - registered copy of SYS_CLK_LOCKED (input-rate enable)
//   SYS_CLK_OUT     - enable strobe at SYSCLK_FREQ
//   CLKOUT1..4      - enable strobes at CLKOUT1_FREQ..CLKOUT4_FREQ
//   SYS_CLK_LOCKED  - high once the lock interval has elapsed
module clk_mgr_a #(
  parameter longint INPUT_CLOCK_FREQ = 100_000_000,
  parameter longint SYSCLK_FREQ      = 80_000_000,
  parameter longint CLKOUT1_FREQ     = 80_000_000,
  parameter longint CLKOUT2_FREQ     = 25_000_000,
  parameter longint CLKOUT3_FREQ     = 150_000_000,
  parameter longint CLKOUT4_FREQ     = 250_000_000,
  parameter int     ACC_WIDTH        = 32,
  parameter int     LOCK_CYCLES      = 64,
  parameter         FPGA_FAMILY      = "ZYNQ7000"
) (
  input  logic OSC_IN,
  input  logic RST,
  output logic OSC_OUT,
  output logic SYS_CLK_OUT,
  output logic CLKOUT1,
  output logic CLKOUT2,
  output logic CLKOUT3,
  output logic CLKOUT4,
  output logic SYS_CLK_LOCKED
);

  // The family name is descriptive only. It is referenced here so that it is
  // part of the elaborated design, but it never selects any hardware.
  if (FPGA_FAMILY == '0) begin : gNoFamily
  end

  // Channel 0 is SYS_CLK_OUT. Channels 1..4 are CLKOUT1..CLKOUT4.
  localparam longint FREQ [5] = '{SYSCLK_FREQ, CLKOUT1_FREQ, CLKOUT2_FREQ,
                                  CLKOUT3_FREQ, CLKOUT4_FREQ};

  // INC = floor(F * 2^ACC_WIDTH / INPUT_CLOCK_FREQ).
  // The numerator is computed in 128 bits so that it cannot overflow.
  function automatic logic [ACC_WIDTH-1:0] calcInc(input longint freq);
    logic [127:0] num;
    num = 128'(freq) << ACC_WIDTH;
    return ACC_WIDTH'(num / 128'(INPUT_CLOCK_FREQ));
  endfunction

  localparam int CNT_W = (LOCK_CYCLES > 0) ? $clog2(LOCK_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);

  logic [CNT_W-1:0] lockCnt_q, lockCnt_d;
  logic             locked_q, locked_d;
  logic             oscOut_q;
  logic [4:0]       strobes;

  // The lock counter saturates at LOCK_MAX. Lock is set on the same edge
  // at which the counter reaches LOCK_MAX, and it stays set until RST.
  // When LOCK_CYCLES is 0, the counter is already at LOCK_MAX, so lock is
  // set on the first edge after reset is released.
  always_comb begin
    lockCnt_d = lockCnt_q;
    if (lockCnt_q != LOCK_MAX) begin
      lockCnt_d = lockCnt_q + CNT_W'(1);
    end
    locked_d = locked_q | (lockCnt_d == LOCK_MAX);
  end

  always_ff @(posedge OSC_IN) begin
    if (RST) begin
      lockCnt_q <= '0;
      locked_q  <= 1'b0;
      oscOut_q  <= 1'b0;
    end else begin
      lockCnt_q <= lockCnt_d;
      locked_q  <= locked_d;
      oscOut_q  <= locked_q;
    end
  end

  for (genvar g = 0; g < 5; g++) begin : gCh
    localparam longint F = FREQ[g];

    logic strobe_q, strobe_d;

    if (F == 0) begin : gZero
      assign strobe_d = 1'b0;
    end else if (F >= INPUT_CLOCK_FREQ) begin : gSat
      // Saturated channel: it is an enable on every cycle. It follows
      // locked_d so that the strobe rises together with SYS_CLK_LOCKED.
      assign strobe_d = locked_d;
    end else begin : gAcc
      localparam logic [ACC_WIDTH-1:0] INC = calcInc(F);

      logic [ACC_WIDTH-1:0] acc_q, acc_d;
      logic                 carry;

      assign {carry, acc_d} = {1'b0, acc_q} + {1'b0, INC};
      assign strobe_d       = locked_q & carry;

      // The accumulator is held at zero until lock. It first advances on
      // the first cycle in which locked_q is high.
      always_ff @(posedge OSC_IN) begin
        if (RST) begin
          acc_q <= '0;
        end else if (locked_q) begin
          acc_q <= acc_d;
        end else begin
          acc_q <= '0;
        end
      end
    end

    always_ff @(posedge OSC_IN) begin
      if (RST) begin
        strobe_q <= 1'b0;
      end else begin
        strobe_q <= strobe_d;
      end
    end

    assign strobes[g] = strobe_q;
  end

  assign SYS_CLK_LOCKED = locked_q;
  assign OSC_OUT        = oscOut_q;
  assign SYS_CLK_OUT    = strobes[0];
  assign CLKOUT1        = strobes[1];
  assign CLKOUT2        = strobes[2];
  assign CLKOUT3        = strobes[3];
  assign CLKOUT4        = strobes[4];

endmodule

// File: tb/tb_clk_mgr_a.sv
// tb_clk_mgr_a
//
// Testbench for clk_mgr_a. CLKOUT1 is configured to 0 Hz; every other
// parameter keeps its default value. Each cycle, the expected outputs are
// derived from the accumulator rate formula and pushed into a scoreboard
// queue. They are popped and compared just after the following rising edge.
module tb_clk_mgr_a;

  localparam int              LOCK    = 64;
  localparam longint unsigned SYS_INC = 64'd3435973836;
  localparam longint unsigned C2_INC  = 64'd1073741824;

  typedef enum logic {FIRST_LOCK, AFTER_RESET} epochT;

  typedef struct packed {
    logic [1:0] lock;
    logic [4:0] strobes;
  } expT;

  logic OSC_IN;
  logic RST;
  logic OSC_OUT, SYS_CLK_OUT, CLKOUT1, CLKOUT2, CLKOUT3, CLKOUT4;
  logic SYS_CLK_LOCKED;

  expT   sb[$];
  int    checks;
  int    errors;
  int    relCnt;
  epochT epoch;

  int    sysPulses;
  bit    sysSeenPulse;
  bit    sysPrevLow;
  int    sysDoubleLow;
  int    c2Last;
  bit    c1Seen;
  bit    relockSeen;

  clk_mgr_a #(
    .CLKOUT1_FREQ(0)
  ) dut (
    .OSC_IN        (OSC_IN),
    .RST           (RST),
    .OSC_OUT       (OSC_OUT),
    .SYS_CLK_OUT   (SYS_CLK_OUT),
    .CLKOUT1       (CLKOUT1),
    .CLKOUT2       (CLKOUT2),
    .CLKOUT3       (CLKOUT3),
    .CLKOUT4       (CLKOUT4),
    .SYS_CLK_LOCKED(SYS_CLK_LOCKED)
  );

  // 100 MHz input clock.
  initial OSC_IN = 1'b0;
  always #5 OSC_IN = ~OSC_IN;

  // Counts one comparison. Reports the comparison if it fails.
  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Gives the strobe produced by the k-th accumulation (k >= 1): 1 when
  // floor(k*INC/2^32) steps up relative to floor((k-1)*INC/2^32).
  function automatic logic accStrobe(input longint unsigned inc, input int k);
    longint unsigned kk;
    kk = longint'(k);
    return ((kk * inc) >> 32) != (((kk - 1) * inc) >> 32);
  endfunction

  // Drives RST for one cycle and pushes the expected post-edge outputs.
  // After the edge, pops the expectation, compares it with the outputs and
  // updates the rate statistics.
  task automatic applyStimulus(input logic rstVal);
    expT e;
    expT got;
    int  k;
    @(negedge OSC_IN);
    RST = rstVal;
    if (rstVal) relCnt = 0;
    else        relCnt++;
    e = '0;
    if (!rstVal) begin
      k = relCnt - LOCK;
      e.lock[1]    = (relCnt >= LOCK);
      e.lock[0]    = (relCnt >= LOCK + 1);
      e.strobes[0] = (k >= 1) ? accStrobe(SYS_INC, k) : 1'b0;
      e.strobes[1] = 1'b0;
      e.strobes[2] = (k >= 1) ? accStrobe(C2_INC, k) : 1'b0;
      e.strobes[3] = (relCnt >= LOCK);
      e.strobes[4] = (relCnt >= LOCK);
    end
    sb.push_back(e);

    @(posedge OSC_IN);
    #1;
    got.lock    = {SYS_CLK_LOCKED, OSC_OUT};
    got.strobes = {CLKOUT4, CLKOUT3, CLKOUT2, CLKOUT1, SYS_CLK_OUT};
    checkOutput("sbDepth", 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("lock", 64'(got.lock), 64'(e.lock));
      checkOutput("strobes", 64'(got.strobes), 64'(e.strobes));
    end

    if (CLKOUT1 !== 1'b0) c1Seen = 1'b1;

    if (!rstVal && epoch == FIRST_LOCK && SYS_CLK_LOCKED === 1'b1) begin
      if (relCnt - LOCK + 1 <= 100 && SYS_CLK_OUT === 1'b1) sysPulses++;
      if (sysSeenPulse && sysPrevLow && SYS_CLK_OUT !== 1'b1) sysDoubleLow++;
      if (SYS_CLK_OUT === 1'b1) sysSeenPulse = 1'b1;
      sysPrevLow = (SYS_CLK_OUT !== 1'b1);
      if (CLKOUT2 === 1'b1) begin
        if (c2Last < 0) checkOutput("c2First", 64'(relCnt - LOCK), 64'd4);
        else            checkOutput("c2Period", 64'(relCnt - c2Last), 64'd4);
        c2Last = relCnt;
      end
    end

    if (!rstVal && epoch == AFTER_RESET && !relockSeen &&
        SYS_CLK_LOCKED === 1'b1) begin
      checkOutput("relockDelay", 64'(relCnt), 64'(LOCK));
      relockSeen = 1'b1;
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    relCnt       = 0;
    epoch        = FIRST_LOCK;
    sysPulses    = 0;
    sysSeenPulse = 1'b0;
    sysPrevLow   = 1'b0;
    sysDoubleLow = 0;
    c2Last       = -1;
    c1Seen       = 1'b0;
    relockSeen   = 1'b0;
    RST          = 1'b1;

    $display("[TB] reset for 5 cycles");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1);

    // Runs until locked cycle 500 (lock starts at relCnt 64, which is
    // locked cycle 1).
    $display("[TB] running to locked cycle 500");
    for (int i = 0; i < LOCK + 499; i++) applyStimulus(1'b0);

    $display("[TB] mid-run reset pulse");
    epoch = AFTER_RESET;
    applyStimulus(1'b1);
    for (int i = 0; i < 150; i++) applyStimulus(1'b0);

    checkOutput("sysPulses100", 64'(sysPulses), 64'd79);
    checkOutput("sysDoubleLow", 64'(sysDoubleLow), 64'd0);
    checkOutput("c2Seen", 64'(c2Last >= 0), 64'd1);
    checkOutput("c1EverHigh", 64'(c1Seen), 64'd0);
    checkOutput("relockSeen", 64'(relockSeen), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
